// File: rtl/ara_inval_sequencer.sv
// ara_inval_sequencer
// Converts queued address ranges into a stream of single-line L1 D-cache
// invalidations towards CVA6. Each range is given as a start byte address
// plus a line count minus one. Ranges are issued strictly in arrival order,
// with lines ascending inside each range. If a range starts on the line that
// was invalidated last, that line is not sent a second time.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   en_i             coherence enable; while low no new ranges are accepted
//   rng_valid_i      range request valid
//   rng_ready_o      range request accepted (en_i && queue not full)
//   rng_addr_i       range start byte address, any alignment
//   rng_len_i        number of lines in the range minus one
//   inval_valid_o    line invalidation valid
//   inval_addr_o     line-aligned invalidation address
//   inval_ready_i    invalidation accepted by CVA6
//   busy_o           ranges queued or a sequence in flight
//   pending_o        queued ranges not yet started
//
// Handshakes: a transfer takes place on a rising edge where valid and ready
// are both high. Once valid is raised it stays high, and its payload stays
// stable, until that transfer takes place. Ready may depend on current-cycle
// state, but never on the valid of the same channel.
module ara_inval_sequencer #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned Depth       = 4,
    parameter int unsigned LenWidth    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic                       rng_valid_i,
    output logic                       rng_ready_o,
    input  logic [AddrWidth-1:0]       rng_addr_i,
    input  logic [LenWidth-1:0]        rng_len_i,
    output logic                       inval_valid_o,
    output logic [AddrWidth-1:0]       inval_addr_o,
    input  logic                       inval_ready_i,
    output logic                       busy_o,
    output logic [$clog2(Depth+1)-1:0] pending_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth+1);
    localparam logic [AddrWidth-1:0] LineStep = AddrWidth'(L1LineWidth);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  cur_addr_q, cur_addr_d;
    logic [LenWidth-1:0]   rem_q, rem_d;
    logic [AddrWidth-1:0]  last_line_q, last_line_d;
    logic                  last_vld_q, last_vld_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [AddrWidth-1:0]  qaddr_q [Depth];
    logic [AddrWidth-1:0]  qaddr_d [Depth];
    logic [LenWidth-1:0]   qlen_q  [Depth];
    logic [LenWidth-1:0]   qlen_d  [Depth];

    logic                  full, empty, push, hs, want_load, bypass;
    logic                  load_valid, pop, enqueue, match_vld, skip;
    logic [AddrWidth-1:0]  in_base, ld_base, match_line;
    logic [LenWidth-1:0]   ld_len;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign in_base = rng_addr_i & ~(LineStep - AddrWidth'(1));

    assign rng_ready_o = en_i && !full;
    assign push        = rng_valid_i && rng_ready_o;
    assign hs          = (state_q == ISSUE) && inval_ready_i;

    // A new entry is loaded either from IDLE or on the final line's handshake.
    assign want_load = (state_q == IDLE) || (hs && (rem_q == '0));
    // In IDLE with an empty queue the incoming range goes straight to the
    // sequencer, which gives the one-cycle push-to-issue latency.
    assign bypass     = (state_q == IDLE) && empty && push;
    assign load_valid = want_load && (!empty || bypass);
    assign pop        = load_valid && !empty;
    assign enqueue    = push && !bypass;

    assign ld_base = empty ? in_base   : qaddr_q[rd_ptr_q];
    assign ld_len  = empty ? rng_len_i : qlen_q[rd_ptr_q];

    // The line handshaken in this very cycle counts as the most recent line,
    // so back-to-back loads see it without waiting for last_line_q.
    assign match_line = hs ? cur_addr_q : last_line_q;
    assign match_vld  = en_i && (hs || last_vld_q);
    assign skip       = match_vld && (ld_base == match_line);

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_d       = rem_q;
        last_line_d = last_line_q;
        last_vld_d  = en_i && (hs || last_vld_q);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        qaddr_d     = qaddr_q;
        qlen_d      = qlen_q;

        if (hs) begin
            last_line_d = cur_addr_q;
        end

        if (enqueue) begin
            qaddr_d[wr_ptr_q] = in_base;
            qlen_d[wr_ptr_q]  = rng_len_i;
            wr_ptr_d          = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(enqueue) - CntW'(pop);

        if (hs && (rem_q != '0)) begin
            cur_addr_d = cur_addr_q + LineStep;
            rem_d      = rem_q - LenWidth'(1);
        end else if (want_load) begin
            if (!load_valid) begin
                state_d = IDLE;
            end else if (skip && (ld_len == '0)) begin
                // Range covers only the line just invalidated: drop it.
                state_d = IDLE;
            end else if (skip) begin
                state_d    = ISSUE;
                cur_addr_d = ld_base + LineStep;
                rem_d      = ld_len - LenWidth'(1);
            end else begin
                state_d    = ISSUE;
                cur_addr_d = ld_base;
                rem_d      = ld_len;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            last_line_q <= '0;
            last_vld_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                qaddr_q[i] <= '0;
                qlen_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            last_line_q <= last_line_d;
            last_vld_q  <= last_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            qaddr_q     <= qaddr_d;
            qlen_q      <= qlen_d;
        end
    end

    assign inval_valid_o = (state_q == ISSUE);
    assign inval_addr_o  = cur_addr_q;
    assign pending_o     = count_q;
    assign busy_o        = (count_q != '0) || (state_q == ISSUE);

endmodule

// File: tb/tb_ara_inval_sequencer.sv
// Bench for ara_inval_sequencer with 16-byte lines, a 4-entry queue and
// 64-bit addresses. Expected invalidation addresses are queued when a range
// is accepted and consumed by a monitor on every output handshake.
module tb_ara_inval_sequencer;
    localparam int AW   = 64;
    localparam int LW   = 16;
    localparam int DEP  = 4;
    localparam int LENW = 8;
    localparam int CW   = $clog2(DEP+1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            rng_valid;
    logic            rng_ready;
    logic [AW-1:0]   rng_addr;
    logic [LENW-1:0] rng_len;
    logic            inval_valid;
    logic [AW-1:0]   inval_addr;
    logic            inval_ready;
    logic            busy;
    logic [CW-1:0]   pending;

    ara_inval_sequencer #(
        .AddrWidth(AW), .L1LineWidth(LW), .Depth(DEP), .LenWidth(LENW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .rng_valid_i(rng_valid), .rng_ready_o(rng_ready),
        .rng_addr_i(rng_addr), .rng_len_i(rng_len),
        .inval_valid_o(inval_valid), .inval_addr_o(inval_addr),
        .inval_ready_i(inval_ready), .busy_o(busy), .pending_o(pending)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_vec  = 0;
    int            n_fail = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] m_last;
    bit            m_vld;
    bit            hold_prev;
    logic [AW-1:0] hold_addr;
    int            out_cnt;

    function automatic void chk(input string name, input logic [AW-1:0] act,
                                input logic [AW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: a range expands to its lines in ascending order; its first
    // line is dropped when it equals the last line already invalidated.
    function automatic void model_push(input logic [AW-1:0] addr,
                                       input logic [LENW-1:0] len);
        logic [AW-1:0] base;
        logic [AW-1:0] line;
        int first;
        base  = addr - (addr % LW);
        first = (m_vld && (base == m_last)) ? 1 : 0;
        for (int i = first; i <= int'(len); i++) begin
            line = base + AW'(i * LW);
            exp_q.push_back(line);
            m_last = line;
            m_vld  = 1'b1;
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", AW'(inval_valid), AW'(1));
                chk("hold_addr", inval_addr, hold_addr);
            end
            if (inval_valid) out_cnt++;
            if (inval_valid && inval_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_inval: got %h expected none", inval_addr);
                end else begin
                    chk("inval_addr", inval_addr, exp_q.pop_front());
                end
            end
            hold_prev = inval_valid && !inval_ready;
            hold_addr = inval_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [LENW-1:0] l,
                        output bit acc);
        rng_valid = 1'b1;
        rng_addr  = a;
        rng_len   = l;
        @(negedge clk);
        acc = rng_ready;
        if (acc) model_push(a, l);
        cycle();
        rng_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        inval_ready = 1'b1;
        while (busy && k < 300) begin
            cycle();
            k++;
        end
        chk("drain_busy", AW'(busy), AW'(0));
        cycle();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        logic [AW-1:0] a;
        rst_n = 1'b1; en = 1'b1; rng_valid = 1'b0; rng_addr = '0; rng_len = '0;
        inval_ready = 1'b0; m_vld = 1'b0; m_last = '0; out_cnt = 0;
        hold_prev = 1'b0; hold_addr = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid",   AW'(inval_valid), AW'(0));
        chk("rst_addr",    inval_addr, AW'(0));
        chk("rst_busy",    AW'(busy), AW'(0));
        chk("rst_pending", AW'(pending), AW'(0));
        chk("rst_ready_en1", AW'(rng_ready), AW'(1));
        en = 1'b0;
        #1 chk("rst_ready_en0", AW'(rng_ready), AW'(0));
        en = 1'b1;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();

        // basic range, unaligned start, one-cycle latency
        inval_ready = 1'b1;
        push(64'h1008, 8'd2, acc);
        @(negedge clk);
        chk("lat1_valid", AW'(inval_valid), AW'(1));
        chk("lat1_addr0", inval_addr, 64'h1000);
        cycle(); @(negedge clk);
        chk("lat1_addr1", inval_addr, 64'h1010);
        cycle(); @(negedge clk);
        chk("lat1_addr2", inval_addr, 64'h1020);
        cycle(); @(negedge clk);
        chk("lat1_busy_after", AW'(busy), AW'(0));
        chk("lat1_valid_after", AW'(inval_valid), AW'(0));
        cycle();

        // backpressure: address held while ready is low
        inval_ready = 1'b0;
        push(64'h4000, 8'd1, acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", AW'(inval_valid), AW'(1));
            chk("stall_addr", inval_addr, 64'h4000);
            cycle();
        end
        inval_ready = 1'b1;
        @(negedge clk);
        cycle(); @(negedge clk);
        chk("stall_addr_next", inval_addr, 64'h4010);
        cycle();
        drain();

        // queue full: 1 active + 4 queued, 6th refused
        inval_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(64'h5000 + AW'(i * 256), 8'd0, acc);
            chk("fill_accept", AW'(acc), AW'(1));
        end
        push(64'h5500, 8'd0, acc);
        chk("full_reject", AW'(acc), AW'(0));
        @(negedge clk);
        chk("full_pending", AW'(pending), AW'(4));
        chk("full_ready", AW'(rng_ready), AW'(0));
        cycle();
        inval_ready = 1'b1;
        @(negedge clk);
        cycle();
        inval_ready = 1'b0;
        @(negedge clk);
        chk("free_pending", AW'(pending), AW'(3));
        chk("free_ready", AW'(rng_ready), AW'(1));
        cycle();
        drain();

        // duplicate first line suppressed
        inval_ready = 1'b1;
        push(64'h2000, 8'd0, acc);
        push(64'h2008, 8'd1, acc);
        drain();

        // duplicate kept when enable pulses low in between
        push(64'h2000, 8'd0, acc);
        en = 1'b0;
        m_vld = 1'b0;
        cycle();
        en = 1'b1;
        push(64'h2008, 8'd1, acc);
        drain();

        // address wrap
        push(64'hFFFF_FFFF_FFFF_FFF0, 8'd1, acc);
        drain();

        // reset in the middle of a sequence
        inval_ready = 1'b1;
        push(64'h8000, 8'd7, acc);
        push(64'h9000, 8'd0, acc);
        push(64'hA000, 8'd0, acc);
        inval_ready = 1'b0;
        @(negedge clk);
        chk("mid_addr", inval_addr, 64'h8020);
        chk("mid_pending", AW'(pending), AW'(2));
        #1 rst_n = 1'b0;
        exp_q.delete();
        m_vld = 1'b0;
        #1;
        chk("arst_valid",   AW'(inval_valid), AW'(0));
        chk("arst_pending", AW'(pending), AW'(0));
        chk("arst_busy",    AW'(busy), AW'(0));
        cycle(); cycle();
        rst_n = 1'b1;
        inval_ready = 1'b1;
        out_cnt = 0;
        repeat (10) cycle();
        chk("post_reset_outputs", AW'(out_cnt), AW'(0));

        // randomized traffic with enable held high
        for (int c = 0; c < 500; c++) begin
            inval_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0:       a = m_last + AW'($urandom_range(0, 15));
                    1:       a = {$urandom, $urandom};
                    2:       a = 64'h1000 + AW'($urandom_range(0, 31) * 8);
                    default: a = 64'hFFFF_FFFF_FFFF_FFC0 + AW'($urandom_range(0, 63));
                endcase
                push(a, LENW'($urandom_range(0, 3)), acc);
            end else begin
                cycle();
            end
        end
        drain();
        chk("leftover_expected", AW'(exp_q.size()), AW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ara_inval_sequencer.md
ARA_INVAL_SEQUENCER -- requirements
Module: ara_inval_sequencer

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, address width in bits.
REQ-002 SHALL have parameter L1LineWidth, default 16, L1 D-cache line size in bytes (power of two).
REQ-003 SHALL have parameter Depth, default 4, range-queue entries (power of two, >=2).
REQ-004 SHALL have parameter LenWidth, default 8, width of range length field.
REQ-005 SHALL have port clk_i  input  1  clock; one clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en_i  input  1  coherence enable (acc_cons_en).
REQ-008 SHALL have port rng_valid_i  input  1  range request valid.
REQ-009 SHALL have port rng_ready_o  output  1  range request accepted.
REQ-010 SHALL have port rng_addr_i  input  AddrWidth  range start byte address, any alignment.
REQ-011 SHALL have port rng_len_i  input  LenWidth  number of lines minus one.
REQ-012 SHALL have port inval_valid_o  output  1  line invalidation valid, to CVA6.
REQ-013 SHALL have port inval_addr_o  output  AddrWidth  line-aligned invalidation address.
REQ-014 SHALL have port inval_ready_i  input  1  CVA6 accepts invalidation.
REQ-015 SHALL have port busy_o  output  1  queue non-empty or sequence in progress.
REQ-016 SHALL have port pending_o  output  $clog2(Depth+1)  queued ranges not yet started.

Function
REQ-017 SHALL accept a range (push) when rng_valid_i && rng_ready_o; rng_ready_o = en_i && !full, independent of same-cycle pop.
REQ-018 SHALL store per entry: line-aligned address (low $clog2(L1LineWidth) bits zeroed) and rng_len_i.
REQ-019 SHALL implement FSM IDLE/ISSUE; IDLE: inval_valid_o=0; queue non-empty -> pop head, load cur_addr, rem -> ISSUE.
REQ-020 SHALL in ISSUE drive inval_valid_o=1, inval_addr_o=cur_addr; hold both stable until inval_ready_i.
REQ-021 SHALL on handshake with rem!=0: cur_addr += L1LineWidth (modulo 2^AddrWidth), rem -= 1, stay ISSUE.
REQ-022 SHALL on handshake with rem==0: if queue non-empty, pop and load next entry same cycle (no bubble); else -> IDLE.
REQ-023 SHALL give latency 1: range pushed in cycle t into empty queue while IDLE -> inval_valid_o=1 in cycle t+1.
REQ-024 SHALL track last_line (address of last handshaken invalidation) plus last_vld flag.
REQ-025 SHALL, when loading an entry whose aligned base == last_line && last_vld: len==0 -> discard entry; else start at base+L1LineWidth with rem=len-1.
REQ-026 SHALL clear last_vld whenever en_i==0.
REQ-027 SHALL, when en_i falls, stop accepting but finish current and queued ranges.
REQ-028 SHALL allow push and pop in same cycle; pending_o = entries in queue, excluding the active sequence.
REQ-029 SHALL assert busy_o = (pending_o!=0) || (state==ISSUE), combinationally.
REQ-030 SHALL never drop or reorder ranges; invalidations issued in push order, ascending line order within a range.

Reset
REQ-031 SHALL on rst_ni low immediately force: state IDLE, queue empty, last_vld=0, cur_addr=0, rem=0.
REQ-032 SHALL drive reset outputs: inval_valid_o=0, inval_addr_o=0, busy_o=0, pending_o=0, rng_ready_o=en_i.
REQ-033 SHALL on reset mid-sequence abandon all outstanding lines; no invalidation after reset release unless new range pushed.

Verification (L1LineWidth=16, Depth=4, AddrWidth=64)
REQ-034 SHALL cover: push 0x1008 len 2, inval_ready_i=1 -> inval_addr_o 0x1000,0x1010,0x1020 on three consecutive cycles starting t+1; busy_o=0 after.
REQ-035 SHALL cover: push 0x4000 len 1, inval_ready_i=0 for 5 cycles -> inval_valid_o=1, inval_addr_o=0x4000 held 5 cycles; then 0x4000, 0x4010.
REQ-036 SHALL cover: inval_ready_i=0, push 5 ranges back-to-back -> first 5 accepted (1 active + 4 queued), pending_o=4, rng_ready_o=0 on 6th; one handshake frees slot next cycle.
REQ-037 SHALL cover: push 0x2000 len 0 then 0x2008 len 1, ready=1 -> outputs 0x2000, 0x2010 only; with en_i pulsed low between them -> 0x2000, 0x2000, 0x2010.
REQ-038 SHALL cover: push 0xFFFF_FFFF_FFFF_FFF0 len 1 -> outputs 0xFFFF_FFFF_FFFF_FFF0 then 0x0.
REQ-039 SHALL cover: rst_ni asserted during 3rd line of len-7 range with 2 queued -> same cycle inval_valid_o=0, pending_o=0, busy_o=0; no output after release.
